controlador_disco: RTL and testbench

- DMA-style disk controller that drives the disk port (clk, we, addr, datain, dataout) of the 32-bit disk memory.
- Copies a block of words in either direction between disk and main memory:
  - LOAD: disk to memory, used by the OS loader to bring programs in.
  - STORE: memory to disk, used to save process images.
- Sits between the CPU's I/O command path and the disk/memory ports. The CPU stalls on busy.

---
 rtl/controlador_disco_pkg.sv | 21 ++
 rtl/controlador_disco_if.sv | 49 ++++
 rtl/controlador_disco_cnt.sv | 63 ++++++
 rtl/controlador_disco.sv | 136 +++++++++++++
 tb/tb_controlador_disco.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_disco_pkg.sv
// Shared definitions for the disk DMA controller: default widths, transfer
// direction codes and the controller state encoding.
package controlador_disco_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_DISK_SIZE = 500;

    // Transfer direction as seen on the dir input.
    localparam logic DIR_LOAD  = 1'b0;  // disk -> memory
    localparam logic DIR_STORE = 1'b1;  // memory -> disk

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        PUT    = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/controlador_disco_if.sv
// Command and bus bundle of the disk DMA controller.
//   CPU command : start, dir, disk_base, mem_base, count
//   CPU status  : busy, done, err, words_done
//   Disk port   : disk_we, disk_addr, disk_wdata, disk_rdata
//   Memory port : mem_we, mem_addr, mem_wdata, mem_rdata
// The controller connects through the slave modport; the surrounding system
// (CPU, disk and memory) connects through the master modport.
interface controlador_disco_if
    import controlador_disco_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] disk_base;
    logic [ADDR_W-1:0] mem_base;
    logic [CNT_W-1:0]  count;

    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  words_done;

    logic              disk_we;
    logic [ADDR_W-1:0] disk_addr;
    logic [DATA_W-1:0] disk_wdata;
    logic [DATA_W-1:0] disk_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  start, dir, disk_base, mem_base, count, disk_rdata, mem_rdata,
        output busy, done, err, words_done,
        output disk_we, disk_addr, disk_wdata, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output start, dir, disk_base, mem_base, count, disk_rdata, mem_rdata,
        input  busy, done, err, words_done,
        input  disk_we, disk_addr, disk_wdata, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/controlador_disco_cnt.sv
// Word index / address generator for the disk DMA controller.
// Latches the command on load, steps the word index on inc and presents the
// current disk and memory addresses (base + index) plus a last-word flag.
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : latch command fields and clear the index
//   inc             : advance to the next word
//   dir_in, *_in    : command fields to latch
//   dir             : latched direction
//   disk_addr       : latched disk base + index
//   mem_addr        : latched memory base + index (wraps modulo 2^ADDR_W)
//   idx             : words transferred so far
//   last            : the current word is the final one of the block
module controlador_disco_cnt
    import controlador_disco_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic              dir_in,
    input  logic [ADDR_W-1:0] disk_base_in,
    input  logic [ADDR_W-1:0] mem_base_in,
    input  logic [CNT_W-1:0]  count_in,
    output logic              dir,
    output logic [ADDR_W-1:0] disk_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CNT_W-1:0]  idx,
    output logic              last
);

    logic [ADDR_W-1:0] disk_base_q;
    logic [ADDR_W-1:0] mem_base_q;
    logic [CNT_W-1:0]  count_q;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir         <= DIR_LOAD;
            disk_base_q <= '0;
            mem_base_q  <= '0;
            count_q     <= '0;
            idx         <= '0;
        end else if (load) begin
            dir         <= dir_in;
            disk_base_q <= disk_base_in;
            mem_base_q  <= mem_base_in;
            count_q     <= count_in;
            idx         <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign disk_addr = disk_base_q + ADDR_W'(idx);
    assign mem_addr  = mem_base_q + ADDR_W'(idx);

    // One extra bit so idx + 1 cannot wrap back onto a small count.
    assign last = ((CNT_W+1)'(idx) + (CNT_W+1)'(1)) == (CNT_W+1)'(count_q);

endmodule

// File: rtl/controlador_disco.sv
// DMA-style disk controller. Copies count words between disk and main memory,
// two cycles per word (FETCH drives the source address, PUT writes the
// destination with the read data), then pulses done. Commands whose disk
// range runs past DISK_SIZE are rejected with a one-cycle err pulse.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset, aborts any transfer
//   bus   : command, status, disk port and memory port (slave modport)
module controlador_disco
    import controlador_disco_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DISK_SIZE = DEF_DISK_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    controlador_disco_if.slave   bus
);

    state_t            state, state_nxt;
    logic              done_q, err_q, done_nxt, err_nxt;
    logic              cnt_load, cnt_inc;
    logic              dir_q, last;
    logic [ADDR_W-1:0] cur_disk, cur_mem;
    logic [CNT_W-1:0]  idx;
    logic [ADDR_W:0]   end_addr;
    logic              range_bad;

    logic              busy, disk_we, mem_we;
    logic [ADDR_W-1:0] disk_addr, mem_addr;
    logic [DATA_W-1:0] disk_wdata, mem_wdata;

    controlador_disco_cnt #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (cnt_load),
        .inc          (cnt_inc),
        .dir_in       (bus.dir),
        .disk_base_in (bus.disk_base),
        .mem_base_in  (bus.mem_base),
        .count_in     (bus.count),
        .dir          (dir_q),
        .disk_addr    (cur_disk),
        .mem_addr     (cur_mem),
        .idx          (idx),
        .last         (last)
    );

    // Range check one bit wider than the address so a huge base cannot wrap
    // into the valid window.
    assign end_addr  = {1'b0, bus.disk_base} + (ADDR_W+1)'(bus.count);
    assign range_bad = end_addr > (ADDR_W+1)'(DISK_SIZE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_nxt  = state;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        busy       = 1'b0;
        disk_we    = 1'b0;
        mem_we     = 1'b0;
        disk_addr  = '0;
        mem_addr   = '0;
        disk_wdata = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (range_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        cnt_load  = 1'b1;
                        state_nxt = (bus.count == '0) ? FINISH : FETCH;
                    end
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (dir_q == DIR_LOAD) disk_addr = cur_disk;
                else                   mem_addr  = cur_mem;
                state_nxt = PUT;
            end
            PUT: begin
                // Both addresses stay on the bus: the source keeps its read
                // address so its falling-edge data output holds through PUT.
                busy      = 1'b1;
                disk_addr = cur_disk;
                mem_addr  = cur_mem;
                cnt_inc   = 1'b1;
                if (dir_q == DIR_LOAD) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.disk_rdata;
                end else begin
                    disk_we    = 1'b1;
                    disk_wdata = bus.mem_rdata;
                end
                state_nxt = last ? FINISH : FETCH;
            end
            FINISH: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.words_done = idx;
    assign bus.disk_we    = disk_we;
    assign bus.disk_addr  = disk_addr;
    assign bus.disk_wdata = disk_wdata;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_controlador_disco.sv
// Bench for controlador_disco: disk and memory models on the bus, a command
// driver that predicts each command's observable events into a queue, and a
// monitor that pops and compares whenever the DUT writes, finishes or rejects.
module tb_controlador_disco;
    import controlador_disco_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int DSZ = 500;

    localparam int EV_MEM  = 0;
    localparam int EV_DISK = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   mon_en = 1'b0;
    bit   load_img = 1'b1;
    ev_t  exp_q[$];

    logic [31:0] init_disk [DSZ];
    logic [31:0] disk      [DSZ];
    logic [31:0] ref_disk  [DSZ];
    bit   [31:0] mem       [bit [31:0]];
    bit   [31:0] ref_mem   [bit [31:0]];

    controlador_disco_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    controlador_disco #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CNT_W     (CW),
        .DISK_SIZE (DSZ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Disk and memory: write on the rising edge, read data updated on the falling edge.
    always @(posedge clk) begin
        if (load_img) begin
            foreach (init_disk[i]) disk[i] = init_disk[i];
            mem[32'd20] = 32'h1234;
            mem[32'd21] = 32'h5678;
        end
        if (bus.disk_we && bus.disk_addr < 32'(DSZ)) disk[int'(bus.disk_addr)] = bus.disk_wdata;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end

    always @(negedge clk) begin
        bus.disk_rdata <= (bus.disk_addr < 32'(DSZ)) ? disk[int'(bus.disk_addr)] : 32'h0;
        bus.mem_rdata  <= mem_rd(bus.mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h at cycle %0d, expected none",
                     kind, addr, data, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_addr", addr, e.addr);
        check("event_data", data, e.data);
    endtask

    // Monitor: busy window, write-enable exclusivity and every output event.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(bus.busy), 32'((cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0));
            check("we_exclusive", 32'(bus.mem_we & bus.disk_we), 32'h0);
            if (bus.mem_we)  expect_ev(EV_MEM, bus.mem_addr, bus.mem_wdata);
            if (bus.disk_we) expect_ev(EV_DISK, bus.disk_addr, bus.disk_wdata);
            if (bus.done)    expect_ev(EV_DONE, 32'h0, 32'(bus.words_done));
            if (bus.err)     expect_ev(EV_ERR, 32'h0, 32'h0);
        end
    end

    // Issue one command in the current cycle, predict its events, then wait for
    // them. glitch_at pulses a spurious start t cycles later; reset_at asserts
    // rst_n low for the cycle t cycles later (0 disables either).
    task automatic run_cmd(input logic d, input logic [31:0] db, input logic [31:0] mb,
                           input logic [15:0] cnt, input int glitch_at, input int reset_at);
        int          c0, nw, limit;
        bit          finished;
        logic [31:0] a, v;
        c0 = cyc;
        bus.dir       = d;
        bus.disk_base = db;
        bus.mem_base  = mb;
        bus.count     = cnt;
        bus.start     = 1'b1;

        if (longint'(db) + longint'(cnt) > longint'(DSZ)) begin
            busy_lo = 1;
            busy_hi = 0;
            exp_q.push_back('{EV_ERR, c0 + 1, 32'h0, 32'h0});
        end else begin
            nw = (reset_at != 0) ? reset_at / 2 : int'(cnt);
            if (nw > int'(cnt)) nw = int'(cnt);
            busy_lo = c0 + 1;
            busy_hi = (reset_at != 0) ? c0 + reset_at : c0 + 2 * int'(cnt);
            for (int k = 0; k < nw; k++) begin
                if (d == DIR_LOAD) begin
                    a = mb + 32'(k);
                    v = ref_disk[int'(db) + k];
                    ref_mem[a] = v;
                    exp_q.push_back('{EV_MEM, c0 + 2 + 2 * k, a, v});
                end else begin
                    a = db + 32'(k);
                    v = ref_rd(mb + 32'(k));
                    ref_disk[int'(db) + k] = v;
                    exp_q.push_back('{EV_DISK, c0 + 2 + 2 * k, a, v});
                end
            end
            if (reset_at == 0)
                exp_q.push_back('{EV_DONE, c0 + 2 * int'(cnt) + 2, 32'h0, 32'(cnt)});
        end

        limit    = 2 * int'(cnt) + 8;
        finished = 1'b0;
        for (int t = 1; t <= limit && !finished; t++) begin
            @(posedge clk);
            #1;
            bus.start     = (glitch_at != 0 && t == glitch_at) ? 1'b1 : 1'b0;
            bus.dir       = 1'($urandom);
            bus.disk_base = $urandom;
            bus.mem_base  = $urandom;
            bus.count     = 16'($urandom);
            if (reset_at != 0 && t == reset_at) rst_n = 1'b0;
            if (reset_at != 0 && t == reset_at + 1) begin
                rst_n = 1'b1;
                check("abort_busy", 32'(bus.busy), 32'h0);
                check("abort_mem_we", 32'(bus.mem_we), 32'h0);
                check("abort_disk_we", 32'(bus.disk_we), 32'h0);
                check("abort_done", 32'(bus.done), 32'h0);
                check("abort_words_done", 32'(bus.words_done), 32'h0);
            end
            if (exp_q.size() == 0 && (reset_at == 0 || t > reset_at)) finished = 1'b1;
        end
        bus.start = 1'b0;
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_timeout: %0d events still pending, expected 0 (started cycle %0d)",
                     exp_q.size(), c0);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        d;
        logic [31:0] db, mb;
        logic [15:0] cnt;
        int          sel;

        bus.start = 1'b0;
        bus.dir = 1'b0;
        bus.disk_base = '0;
        bus.mem_base = '0;
        bus.count = '0;
        foreach (init_disk[i]) init_disk[i] = $urandom;
        for (int i = 0; i < 4; i++) init_disk[i] = 32'hA + 32'(i);
        foreach (init_disk[i]) ref_disk[i] = init_disk[i];
        ref_mem[32'd20] = 32'h1234;
        ref_mem[32'd21] = 32'h5678;

        repeat (3) @(posedge clk);
        #1;
        load_img = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_disk_we", 32'(bus.disk_we), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_words_done", 32'(bus.words_done), 32'h0);
        check("rst_disk_addr", bus.disk_addr, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_disk_wdata", bus.disk_wdata, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run_cmd(DIR_LOAD, 32'd0, 32'd100, 16'd4, 0, 0);
        for (int i = 0; i < 4; i++) check("load_block", mem_rd(32'd100 + 32'(i)), 32'hA + 32'(i));
        check("words_done_hold", 32'(bus.words_done), 32'd4);

        run_cmd(DIR_STORE, 32'd498, 32'd20, 16'd2, 0, 0);
        check("store_disk498", disk[498], 32'h1234);
        check("store_disk499", disk[499], 32'h5678);

        run_cmd(DIR_LOAD, 32'd499, 32'd0, 16'd2, 0, 0);
        run_cmd(DIR_LOAD, 32'd10, 32'd50, 16'd0, 0, 0);
        run_cmd(DIR_LOAD, 32'd100, 32'd200, 16'd5, 3, 0);
        run_cmd(DIR_LOAD, 32'd200, 32'd300, 16'd8, 0, 4);
        run_cmd(DIR_LOAD, 32'd200, 32'd300, 16'd8, 0, 0);

        // Randomized commands, including out-of-range, 32-bit-wrapping disk
        // bases, memory wrap-around and ignored starts mid-transfer.
        for (int n = 0; n < 30; n++) begin
            cnt = 16'($urandom_range(0, 12));
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                db = 32'(DSZ) - 32'(cnt) + 32'($urandom_range(1, 8));
            end else if (sel == 1) begin
                db  = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                cnt = 16'($urandom_range(5, 12));
            end else begin
                db = 32'($urandom_range(0, DSZ - int'(cnt)));
            end
            mb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4))
                                             : 32'($urandom_range(0, 1023));
            d  = 1'($urandom);
            run_cmd(d, db, mb, cnt, (sel == 2 && cnt != 0) ? 3 : 0, 0);
        end

        // Final contents of both memories against the reference model.
        foreach (ref_disk[i]) check("final_disk", disk[i], ref_disk[i]);
        foreach (ref_mem[a]) check("final_mem", mem_rd(a), ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
